fetch_redirect_unit: RTL
========================

Name: fetch_redirect_unit

Overview:
- Owns the architectural fetch PC and selects the next PC each cycle from four sources: sequential, predicted target, redirect-to-fall-through, or redirect-to-resolved-target.
- Sits directly upstream of the branch predictor. It drives pc_o into the predictor's fetch-side lookup and consumes hit_i, predicted_pc_i, wrong_predicted_i and alu_pc_i.
- Carries the fetch PC, the taken-prediction bit and the predicted target through shadow IF/ID and ID/EX registers, so the predictor gets pc_ex_o and hit_ex_o aligned with the EX-stage instruction.
- Generates the pipeline flush and keeps branch and misprediction counters.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- stall_i  in  1  load-use hazard. Holds the PC and IF/ID; inserts a bubble into ID/EX.
- hit_i  in  1  predictor says the fetch PC is a taken branch with a BTB target.
- predicted_pc_i  in  32  BTB target for the fetch PC.
- wrong_predicted_i  in  2  EX verdict: 01 = predicted taken, not taken; 10 = predicted not taken, taken; 00 = agree.
- alu_pc_i  in  32  resolved target of the EX instruction.
- is_cti_ex_i  in  1  EX instruction is B-type, JAL or JALR.
- pc_o  out  32  current fetch PC.
- pc_ex_o  out  32  PC of the EX-stage instruction.
- hit_ex_o  out  1  prediction bit carried to EX.
- flush_o  out  1  kill IF/ID and ID/EX contents this cycle.
- branch_cnt_o  out  CNT_W  count of valid EX control-transfer instructions.
- mispred_cnt_o  out  CNT_W  count of valid EX redirects.

Behaviour:
- Reset (rst_ni=0 at a posedge):
  - pc_o=RESET_PC.
  - Both shadow stages invalid: valid=0, hit=0, pc=0, tgt=0.
  - pc_ex_o=0, hit_ex_o=0, flush_o=0, both counters=0.
  - Reset applied mid-redirect discards the redirect.
- Shadow stage contents: {valid, pc, hit, tgt}. IF/ID is loaded from {1, pc_o, hit_i, predicted_pc_i}.
- ex_valid is the ID/EX valid bit. pc_ex_o and hit_ex_o come from ID/EX; hit_ex_o is forced to 0 when ex_valid=0.
- Redirect conditions (combinational in the EX cycle, all require ex_valid=1):
  - R1: wrong_predicted_i=01 → next PC = pc_ex_o+4.
  - R2: wrong_predicted_i=10 → next PC = alu_pc_i.
  - R3: wrong_predicted_i=00, hit_ex_o=1, is_cti_ex_i=1 and alu_pc_i≠ID/EX.tgt (stale JALR target) → next PC = alu_pc_i.
  - flush_o=R1|R2|R3, asserted combinationally in the same cycle.
- Next-PC priority, highest first:
  1. Reset.
  2. Redirect (overrides stall_i).
  3. stall_i → hold PC.
  4. hit_i → predicted_pc_i.
  5. Otherwise pc_o+4.
- Latency: a redirect detected in cycle N gives the corrected pc_o in cycle N+1. The penalty is 2 squashed instructions.
- Shadow pipeline update per cycle:
  - flush: both stages invalidated (valid=0, hit=0); IF/ID does not capture the current fetch.
  - stall without flush: IF/ID holds; ID/EX takes a bubble (valid=0, hit=0).
  - otherwise: IF/ID←fetch and ID/EX←IF/ID.
- Counters:
  - branch_cnt_o increments when ex_valid & is_cti_ex_i.
  - mispred_cnt_o increments when flush_o.
  - Both saturate at all-ones; they do not wrap.
- Arithmetic: +4 is 32-bit modulo, so 32'hFFFF_FFFC+4 = 0. No alignment check is made on the target; bits [1:0] pass through.
- wrong_predicted_i is ignored while ex_valid=0. Bubbles never redirect and never count.
- Simultaneous redirect and hit_i: the redirect wins and hit_i is dropped.

Decomposition:
- Shared package fetch_pkg holds:
  - the wrong_predicted_i encodings (WP_NONE=2'b00, WP_TAKEN_NOT=2'b01, WP_NOTTAKEN_TAKEN=2'b10);
  - the opcode constants OP_BTYPE, OP_JAL, OP_JALR;
  - the packed struct shadow_stage_t {valid, pc[31:0], hit, tgt[31:0]}.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_ni, inc_i, cnt_o), instantiated twice.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles, then release with hit_i=0 → pc_o = 0, 4, 8, 12 on successive cycles; flush_o=0; counters 0.
- Predicted taken, correct: hit_i=1 with predicted_pc_i=0x40 at pc_o=0x10 → pc_o=0x40 next cycle. Two cycles later pc_ex_o=0x10 and hit_ex_o=1; with wrong_predicted_i=00, alu_pc_i=0x40 and is_cti=1 → no flush, branch_cnt=1.
- R1: EX pc_ex_o=0x20, hit_ex_o=1, wrong_predicted_i=01 → flush_o=1 that cycle; pc_o=0x24 next cycle; hit_ex_o=0 for the next 2 cycles; mispred_cnt=1.
- R2 under stall: wrong_predicted_i=10, alu_pc_i=0x100 and stall_i=1 in the same cycle → pc_o=0x100 next cycle (redirect beats stall).
- R3 stale JALR: hit_ex_o=1, ID/EX.tgt=0x80, alu_pc_i=0x90, wrong_predicted_i=00, is_cti=1 → flush_o=1; pc_o=0x90 next cycle.
- Stall bubble and saturation:
  - stall_i=1 for 3 cycles → pc_o constant, ex_valid=0 in EX, and a concurrent wrong_predicted_i=01 is ignored.
  - With CNT_W=2, 5 redirects → mispred_cnt_o=3.

Source files
------------

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared encodings and shadow-stage layout for the fetch redirect unit.
package fetch_pkg;

  localparam logic [1:0] WP_NONE           = 2'b00;
  localparam logic [1:0] WP_TAKEN_NOT      = 2'b01;
  localparam logic [1:0] WP_NOTTAKEN_TAKEN = 2'b10;

  localparam logic [6:0] OP_BTYPE = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] tgt;
  } shadow_stage_t;

endpackage

// File: rtl/fetch_redirect_unit_sat_counter.sv
// Saturating event counter: +1 per cycle with inc_i, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: picks next PC, tracks IF/ID and ID/EX shadow stages, flushes on redirect.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             hit_i,
  input  logic [31:0]      predicted_pc_i,
  input  logic [1:0]       wrong_predicted_i,
  input  logic [31:0]      alu_pc_i,
  input  logic             is_cti_ex_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_ex_o,
  output logic             hit_ex_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  logic [31:0]   pc_q, pc_d;
  shadow_stage_t ifid_q, ifid_d;
  shadow_stage_t idex_q, idex_d;
  logic          ex_valid;
  logic          redir_ft, redir_tgt;

  assign ex_valid = idex_q.valid;
  assign pc_ex_o  = idex_q.pc;
  assign hit_ex_o = idex_q.hit & ex_valid;

  // Stale-target case: predictor agreed on direction but the BTB target was wrong (JALR).
  always_comb begin
    redir_ft  = ex_valid && (wrong_predicted_i == WP_TAKEN_NOT);
    redir_tgt = ex_valid && ((wrong_predicted_i == WP_NOTTAKEN_TAKEN) ||
                ((wrong_predicted_i == WP_NONE) && hit_ex_o && is_cti_ex_i &&
                 (alu_pc_i != idex_q.tgt)));
  end

  assign flush_o = redir_ft | redir_tgt;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redir_ft)       pc_d = idex_q.pc + 32'd4;
    else if (redir_tgt) pc_d = alu_pc_i;
    else if (stall_i)   pc_d = pc_q;
    else if (hit_i)     pc_d = predicted_pc_i;
  end

  always_comb begin
    ifid_d = '{valid: 1'b1, pc: pc_q, hit: hit_i, tgt: predicted_pc_i};
    idex_d = ifid_q;
    if (flush_o) begin
      ifid_d = '0;
      idex_d = '0;
    end else if (stall_i) begin
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      idex_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      idex_q <= idex_d;
    end
  end

  assign pc_o = pc_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ex_valid & is_cti_ex_i),
    .cnt_o  (branch_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (flush_o),
    .cnt_o  (mispred_cnt_o)
  );

endmodule
